ctrl_modo_vel: RTL and testbench
================================

// Module: ctrl_modo_vel
// PURPOSE
//  Mode/speed controller for the counter-display datapath. Debounces the mode button and
//  cycles STOP/SLOW/MED/FAST modes. Issues count-enable ticks at the selected rate to a
//  3-bit wrap counter. Schedules the two-digit display multiplex select.
//  Replaces free-running clock-select logic with one synchronous clock domain.
// PARAMETERS
//  DEB_LEN     8      consecutive stable synced samples to accept a press/release (>=2)
//  PRE_W       24     prescaler width; must be >= TAP_SLOW
//  TAP_SLOW    23     SLOW tick when prescaler[TAP_SLOW-1:0] all ones (period 2^TAP_SLOW)
//  TAP_MED     22     MED tick tap, same rule
//  TAP_FAST    21     FAST tick tap, same rule
//  SCAN_W      15     display scan counter width; disp_sel toggles every 2^SCAN_W cycles
//  LONG_CYCLES 2^24   long-press hold length in cycles (used only with LONG_PRESS_EN)
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst          in   1  asynchronous, active-high reset
//  on_liga      in   1  run enable (power switch); low = halted and blanked
//  bot          in   1  raw mode button, active high, asynchronous/bouncy
//  press_pulse  out  1  one-cycle pulse per accepted press
//  long_pulse   out  1  one-cycle pulse on long press (constant 0 without macro)
//  mode         out  2  0=STOP 1=SLOW 2=MED 3=FAST
//  tick         out  1  one-cycle count-enable strobe
//  count        out  3  counter value shown on display digit 0
//  disp_sel     out  1  0 = digit 0 (count), 1 = digit 1 (mode)
//  blank        out  1  display blank = ~on_liga (combinational)
// BEHAVIOUR
//  Reset values: press_pulse=0, long_pulse=0, mode=0, tick=0, count=0, disp_sel=0.
//  Internal reset values: FSM=IDLE, all counters 0, synchronizer flops 0.
//  Button input: bot passes a 2-flop synchronizer to bot_s.
//  Debounce FSM (4 states):
//   IDLE:     bot_s=1 goes to DEB_PRESS with deb_cnt=1.
//   DEB_PRESS: bot_s=0 returns to IDLE. Each high sample increments deb_cnt.
//     At DEB_LEN samples, go to PRESSED. press_pulse=1 in the first cycle of PRESSED.
//   PRESSED:  bot_s=0 goes to DEB_REL.
//   DEB_REL:  DEB_LEN consecutive lows go to IDLE. Any high returns to PRESSED with no new pulse.
//  Latency: DEB_LEN+2 cycles from the first high bot sample to press_pulse.
//  on_liga=0 forces the FSM to IDLE and press_pulse to 0. Presses are ignored while on_liga=0.
//  Mode register:
//   Advances at the edge where press_pulse=1: 0->1->2->3->0.
//   The new mode is visible one cycle after the pulse.
//  Prescaler (PRE_W bits):
//   Increments every cycle while on_liga=1.
//   Cleared to 0 when on_liga=0 and at every mode change.
//  Tick rule:
//   tick = on_liga & (mode!=0) & prescaler[TAP(mode)-1:0] all ones & ~press_pulse.
//   Registered, so it appears one cycle after the match.
//  Counter: count increments at edges where tick=1, wrapping 7->0. It holds otherwise.
//  Simultaneous events:
//   Press and tick in the same cycle: mode change wins and the tick is dropped.
//   rst mid-operation: all state returns to reset values immediately.
//  Display scan: the scan counter always runs, independent of on_liga.
//   disp_sel toggles when the scan counter is all ones.
//  blank has no latency.
// CONFIGURATION
//  LONG_PRESS_EN defined:
//   Hold counter runs while in PRESSED or DEB_REL and clears in IDLE.
//   When it reaches LONG_CYCLES: long_pulse=1 for one cycle, count<=0, mode<=0, prescaler<=0.
//   Fires at most once per press. The press_pulse that started the hold is already applied.
//  LONG_PRESS_EN undefined: no hold counter; long_pulse tied to 0.
// TESTING (DEB_LEN=4, TAP_SLOW=4, TAP_MED=3, TAP_FAST=2, SCAN_W=2, LONG_CYCLES=32)
//  1. Reset test: assert rst mid-run, release, hold on_liga=1 for 100 cycles.
//     Expect mode=0, count=0, tick never 1. disp_sel toggles every 4 cycles.
//  2. Debounce test: bot high 3 cycles, low 2 cycles, high 3 cycles, low: no press_pulse.
//     Then bot high 20 cycles: exactly one press_pulse, 6 cycles after the rise. mode=1.
//  3. Mode cycle: 4 clean presses (high 10, low 10 cycles each).
//     Expect mode 1,2,3,0, each 1 cycle after its press_pulse.
//  4. SLOW rate: mode=1 gives a tick every 16 cycles.
//     count steps 0..7 and wraps to 0 after 8 ticks (128 cycles).
//  5. Enable test: mode=3, then drop on_liga for 50 cycles and press bot.
//     Expect tick=0, count held, blank=1, mode stays 3. Raise on_liga: first tick after 4 cycles.
//  6. Long press: mode=2, count=5, hold bot 60 cycles.
//     With LONG_PRESS_EN: press_pulse (mode 3), then long_pulse, mode=0, count=0.
//     Without LONG_PRESS_EN: mode=3, count=5, long_pulse stays 0.

Source files
------------

// File: rtl/ctrl_modo_vel_if.sv
// Control/status bundle between the mode/speed controller and its surroundings.
// Master drives the switch and button; slave (the controller) drives everything else.
interface ctrl_modo_vel_if;
    logic       on_liga;
    logic       bot;
    logic       press_pulse;
    logic       long_pulse;
    logic [1:0] mode;
    logic       tick;
    logic [2:0] count;
    logic       disp_sel;
    logic       blank;

    modport master (
        output on_liga, bot,
        input  press_pulse, long_pulse, mode, tick, count, disp_sel, blank
    );

    modport slave (
        input  on_liga, bot,
        output press_pulse, long_pulse, mode, tick, count, disp_sel, blank
    );
endinterface

// File: rtl/ctrl_modo_vel.sv
// Mode/speed controller: debounced mode button, rate-selected count ticks, 3-bit wrap
// counter and display multiplex select. Define LONG_PRESS_EN to add long-press reset.
module ctrl_modo_vel #(
    parameter int DEB_LEN     = 8,
    parameter int PRE_W       = 24,
    parameter int TAP_SLOW    = 23,
    parameter int TAP_MED     = 22,
    parameter int TAP_FAST    = 21,
    parameter int SCAN_W      = 15,
    parameter int LONG_CYCLES = 1 << 24
) (
    input  logic                  clk,
    input  logic                  rst,
    ctrl_modo_vel_if.slave        bus_if
);

    localparam int DEB_W = $clog2(DEB_LEN + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } deb_state_e;

    logic              sync1_q, bot_s_q;
    deb_state_e        state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              press_q, press_d;
    logic              press_pulse;
    logic              long_pulse;
    logic [1:0]        mode_q;
    logic [PRE_W-1:0]  pre_q;
    logic              tap_match;
    logic              tick_q, tick_d;
    logic [2:0]        count_q;
    logic [SCAN_W-1:0] scan_q;
    logic              disp_sel_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            bot_s_q   <= 1'b0;
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= bus_if.bot;
            bot_s_q   <= sync1_q;
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        press_d   = 1'b0;
        if (!bus_if.on_liga) begin
            state_d   = IDLE;
            deb_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: if (bot_s_q) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = DEB_W'(1);
                end
                DEB_PRESS: if (!bot_s_q) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_W'(DEB_LEN - 1)) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                    press_d   = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
                PRESSED: if (!bot_s_q) begin
                    state_d   = DEB_REL;
                    deb_cnt_d = DEB_W'(1);
                end
                DEB_REL: if (bot_s_q) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_W'(DEB_LEN - 1)) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The pulse is killed the instant the run switch drops, not one cycle later.
    assign press_pulse = press_q & bus_if.on_liga;

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              fired_q;
    logic              long_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state_q == PRESSED || state_q == DEB_REL) begin
                if (!fired_q) begin
                    if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
                        long_q  <= 1'b1;
                        fired_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
            end else begin
                hold_q  <= '0;
                fired_q <= 1'b0;
            end
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

    always_comb begin
        tap_match = 1'b0;
        case (mode_q)
            2'd1:    tap_match = &pre_q[TAP_SLOW-1:0];
            2'd2:    tap_match = &pre_q[TAP_MED-1:0];
            2'd3:    tap_match = &pre_q[TAP_FAST-1:0];
            default: tap_match = 1'b0;
        endcase
    end

    // A mode change (or long-press reset) in the same cycle swallows the tick.
    assign tick_d = bus_if.on_liga & tap_match & ~press_pulse & ~long_pulse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= 2'd0;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            count_q    <= 3'd0;
            scan_q     <= '0;
            disp_sel_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
            if (long_pulse) begin
                mode_q  <= 2'd0;
                count_q <= 3'd0;
            end else begin
                if (press_pulse) mode_q  <= mode_q + 2'd1;
                if (tick_q)      count_q <= count_q + 3'd1;
            end
            if (!bus_if.on_liga || press_pulse || long_pulse) pre_q <= '0;
            else                                              pre_q <= pre_q + PRE_W'(1);
            scan_q <= scan_q + SCAN_W'(1);
            if (&scan_q) disp_sel_q <= ~disp_sel_q;
        end
    end

    assign bus_if.press_pulse = press_pulse;
    assign bus_if.long_pulse  = long_pulse;
    assign bus_if.mode        = mode_q;
    assign bus_if.tick        = tick_q;
    assign bus_if.count       = count_q;
    assign bus_if.disp_sel    = disp_sel_q;
    assign bus_if.blank       = ~bus_if.on_liga;

endmodule

// File: tb/tb_ctrl_modo_vel.sv
// Self-checking bench for ctrl_modo_vel with small debounce/rate parameters.
// Honours LONG_PRESS_EN the same way the design does.
module tb_ctrl_modo_vel;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_modo_vel_if dut_if ();

    ctrl_modo_vel #(
        .DEB_LEN    (4),
        .PRE_W      (8),
        .TAP_SLOW   (4),
        .TAP_MED    (3),
        .TAP_FAST   (2),
        .SCAN_W     (2),
        .LONG_CYCLES(32)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(dut_if.slave)
    );

    typedef struct {
        bit rst_before;
        int hi;
        int lo;
        int exp_pulses;
        int exp_mode;
    } vec_t;

    vec_t vecs[7];
    int   mode_sb[$];
    int   cnt_sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cnt_m   = 0;

    // Independent counter model: count follows ticks, cleared by reset and long press.
    always @(negedge clk) begin
        if (rst)                    cnt_m = 0;
        else if (dut_if.long_pulse) cnt_m = 0;
        else if (dut_if.tick)       cnt_m = (cnt_m + 1) % 8;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dut_if.bot = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic press(input string tag);
        bit seen;
        seen = 1'b0;
        dut_if.bot = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (dut_if.press_pulse) seen = 1'b1;
        end
        check({tag, "_seen"}, 32'(seen), 1);
        step();
        dut_if.bot = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        int prev_mode, pulses, pending, tick_err, ds_err, hold_err;
        int steps, last, ticks, ierr, exp_c, first_tick, cnt_hold;
        int pulse_step, long_step, long_cnt, cnt_after, mode_after;
        bit found;

        vecs[0] = '{1'b1, 3, 2, 0, 0};
        vecs[1] = '{1'b0, 3, 10, 0, 0};
        vecs[2] = '{1'b0, 20, 10, 1, 1};
        vecs[3] = '{1'b1, 10, 10, 1, 1};
        vecs[4] = '{1'b0, 10, 10, 1, 2};
        vecs[5] = '{1'b0, 10, 10, 1, 3};
        vecs[6] = '{1'b0, 10, 10, 1, 0};

        rst = 1'b1;
        dut_if.on_liga = 1'b1;
        dut_if.bot = 1'b0;
        repeat (2) step();
        check("rst_press_pulse", 32'(dut_if.press_pulse), 0);
        check("rst_long_pulse", 32'(dut_if.long_pulse), 0);
        check("rst_mode", 32'(dut_if.mode), 0);
        check("rst_tick", 32'(dut_if.tick), 0);
        check("rst_count", 32'(dut_if.count), 0);
        check("rst_disp_sel", 32'(dut_if.disp_sel), 0);
        check("rst_blank", 32'(dut_if.blank), 0);
        rst = 1'b0;

        // Reset in the middle of SLOW-mode operation.
        press("t1_press");
        repeat (40) step();
        rst = 1'b1;
        #1;
        check("midrst_mode", 32'(dut_if.mode), 0);
        check("midrst_count", 32'(dut_if.count), 0);
        check("midrst_tick", 32'(dut_if.tick), 0);
        step();
        rst = 1'b0;
        tick_err = 0;
        ds_err = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (dut_if.tick) tick_err++;
            if (dut_if.disp_sel !== 1'((k / 4) % 2)) ds_err++;
        end
        check("t1_tick_never", 32'(tick_err), 0);
        check("t1_disp_sel_scan", 32'(ds_err), 0);
        check("t1_mode", 32'(dut_if.mode), 0);
        check("t1_count", 32'(dut_if.count), 0);

        // Debounce and mode-cycle table.
        prev_mode = 0;
        foreach (vecs[i]) begin
            if (vecs[i].rst_before) begin
                do_reset();
                prev_mode = 0;
            end
            if (vecs[i].exp_pulses == 1) mode_sb.push_back(vecs[i].exp_mode);
            pulses = 0;
            pending = 0;
            for (int c = 0; c < vecs[i].hi + vecs[i].lo; c++) begin
                dut_if.bot = (c < vecs[i].hi);
                step();
                if (pending != 0) begin
                    check($sformatf("v%0d_pulse_expected", i), 32'(mode_sb.size()), 1);
                    if (mode_sb.size() > 0)
                        check($sformatf("v%0d_mode_after_pulse", i), 32'(dut_if.mode),
                              32'(mode_sb.pop_front()));
                    pending = 0;
                end
                if (dut_if.press_pulse) begin
                    pulses++;
                    check($sformatf("v%0d_latency", i), 32'(c + 1), 6);
                    check($sformatf("v%0d_mode_at_pulse", i), 32'(dut_if.mode), 32'(prev_mode));
                    pending = 1;
                end
            end
            check($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
            check($sformatf("v%0d_mode", i), 32'(dut_if.mode), 32'(vecs[i].exp_mode));
            mode_sb.delete();
            prev_mode = vecs[i].exp_mode;
        end

        // SLOW rate: tick every 16 cycles, count wraps after 8 ticks.
        do_reset();
        dut_if.bot = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (dut_if.press_pulse) found = 1'b1;
        end
        check("t4_press_seen", 32'(found), 1);
        step();
        dut_if.bot = 1'b0;
        check("t4_mode", 32'(dut_if.mode), 1);
        check("t4_count_start", 32'(dut_if.count), 0);
        steps = 0; last = 0; ticks = 0; ierr = 0; exp_c = 0; pending = 0;
        while (ticks < 8 && steps < 300) begin
            step();
            steps++;
            if (pending != 0) begin
                check($sformatf("t4_count_%0d", ticks), 32'(dut_if.count), 32'(cnt_sb.pop_front()));
                pending = 0;
            end
            if (dut_if.tick) begin
                ticks++;
                if (steps - last != 16) ierr++;
                last = steps;
                exp_c = (exp_c + 1) % 8;
                cnt_sb.push_back(exp_c);
                pending = 1;
            end
        end
        if (pending != 0) begin
            step();
            check("t4_count_wrap", 32'(dut_if.count), 32'(cnt_sb.pop_front()));
        end
        check("t4_ticks", 32'(ticks), 8);
        check("t4_interval", 32'(ierr), 0);
        check("t4_span", 32'(steps), 128);

        // Run enable: halted, blanked, presses ignored.
        do_reset();
        press("t5_p1");
        press("t5_p2");
        press("t5_p3");
        check("t5_mode_fast", 32'(dut_if.mode), 3);
        repeat (5) step();
        dut_if.on_liga = 1'b0;
        #1;
        check("t5_blank_on", 32'(dut_if.blank), 1);
        step();
        cnt_hold = cnt_m;
        hold_err = 0;
        for (int k = 0; k < 50; k++) begin
            dut_if.bot = (k >= 10 && k < 30);
            step();
            if (dut_if.tick || dut_if.press_pulse || dut_if.mode !== 2'd3 || !dut_if.blank)
                hold_err++;
        end
        check("t5_halted", 32'(hold_err), 0);
        check("t5_count_held", 32'(dut_if.count), 32'(cnt_hold));
        dut_if.on_liga = 1'b1;
        first_tick = 0;
        for (int s = 1; s <= 20 && first_tick == 0; s++) begin
            step();
            if (dut_if.tick) first_tick = s;
        end
        check("t5_first_tick", 32'(first_tick), 4);
        check("t5_blank_off", 32'(dut_if.blank), 0);

        // Long press from MED with count 5; the press collides with a due tick.
        do_reset();
        press("t6_p1");
        press("t6_p2");
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (dut_if.tick && cnt_m == 4) found = 1'b1;
        end
        check("t6_sync_found", 32'(found), 1);
        step();
        check("t6_mode_med", 32'(dut_if.mode), 2);
        check("t6_count5", 32'(dut_if.count), 5);
        pulse_step = 0; long_step = 0; long_cnt = 0; cnt_after = -1; mode_after = -1;
        for (int k = 0; k < 60; k++) begin
            dut_if.bot = 1'b1;
            step();
            if (pulse_step != 0 && k + 1 == pulse_step + 1) begin
                cnt_after = dut_if.count;
                mode_after = dut_if.mode;
            end
            if (dut_if.press_pulse) pulse_step = k + 1;
            if (dut_if.long_pulse) begin
                long_cnt++;
                long_step = k + 1;
            end
        end
        dut_if.bot = 1'b0;
        repeat (10) step();
        check("t6_press_latency", 32'(pulse_step), 6);
        check("t6_tick_dropped", 32'(cnt_after), 5);
        check("t6_mode_after_press", 32'(mode_after), 3);
`ifdef LONG_PRESS_EN
        check("t6_long_once", 32'(long_cnt), 1);
        check("t6_long_delay", 32'(long_step - pulse_step), 32);
        check("t6_mode_cleared", 32'(dut_if.mode), 0);
        check("t6_count_cleared", 32'(dut_if.count), 0);
`else
        check("t6_long_never", 32'(long_cnt), 0);
        check("t6_mode_fast", 32'(dut_if.mode), 3);
        check("t6_count_model", 32'(dut_if.count), 32'(cnt_m));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
